// File: rtl/asrv32_mem_responder_if.sv
// rtl/asrv32_mem_responder_if.sv - fetch/load/store request bus between the core and the memory responder
interface asrv32_mem_responder_if;
  logic        req;
  logic        wr_en;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic [31:0] rdata;
  logic        ack;
  logic        err;
  logic        busy;

  modport master (
    output req, wr_en, addr, wdata, wstrb,
    input  rdata, ack, err, busy
  );

  modport slave (
    input  req, wr_en, addr, wdata, wstrb,
    output rdata, ack, err, busy
  );
endinterface

// File: rtl/asrv32_mem_responder.sv
// rtl/asrv32_mem_responder.sv - word-addressed RAM answering one core request at a time with a single-cycle ack
module asrv32_mem_responder #(
  parameter int unsigned MEM_WORDS   = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  asrv32_mem_responder_if.slave bus
);
  localparam int          IW        = $clog2(MEM_WORDS);
  localparam logic [32:0] SPAN      = 33'(MEM_WORDS) << 2;
  localparam logic [3:0]  WAIT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic        wr_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;
  logic [31:0] mem [MEM_WORDS];

  // In IDLE the access comes straight off the bus so a zero-wait access completes on the sampling edge.
  logic        acc_wr;
  logic [31:0] acc_addr;
  logic [31:0] acc_wdata;
  logic [3:0]  acc_wstrb;

  always_comb begin
    acc_wr    = wr_q;
    acc_addr  = addr_q;
    acc_wdata = wdata_q;
    acc_wstrb = wstrb_q;
    if (state == IDLE) begin
      acc_wr    = bus.wr_en;
      acc_addr  = bus.addr;
      acc_wdata = bus.wdata;
      acc_wstrb = bus.wstrb;
    end
  end

  // 33-bit offset: bit 32 flags addresses below the base, and the span compare cannot wrap.
  logic [32:0]   off;
  logic          acc_err;
  logic [IW-1:0] idx;
  logic          enter_resp;

  assign off        = {1'b0, acc_addr} - {1'b0, BASE_ADDR};
  assign acc_err    = off[32] | (off >= SPAN) | (off[1:0] != 2'b00);
  assign idx        = off[IW+1:2];
  assign enter_resp = ((state == IDLE) && bus.req && (WAIT_CYCLES == 0)) ||
                      ((state == WAIT) && (cnt == 4'd0));

  always_ff @(posedge i_clk) begin
    if (i_rst_n && enter_resp && acc_wr && !acc_err) begin
      for (int k = 0; k < 4; k++) begin
        if (acc_wstrb[k]) mem[idx][8*k +: 8] <= acc_wdata[8*k +: 8];
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      wr_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bus.ack   <= 1'b0;
      bus.err   <= 1'b0;
      bus.rdata <= '0;
      bus.busy  <= 1'b0;
    end else begin
      if ((state == IDLE) && bus.req) begin
        wr_q    <= bus.wr_en;
        addr_q  <= bus.addr;
        wdata_q <= bus.wdata;
        wstrb_q <= bus.wstrb;
      end
      if (enter_resp) begin
        state     <= RESP;
        bus.ack   <= 1'b1;
        bus.err   <= acc_err;
        bus.rdata <= (!acc_wr && !acc_err) ? mem[idx] : '0;
        bus.busy  <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            if (bus.req) begin
              state    <= WAIT;
              cnt      <= WAIT_INIT;
              bus.busy <= 1'b1;
            end
          end
          WAIT: cnt <= cnt - 4'd1;
          RESP: begin
            state     <= IDLE;
            bus.ack   <= 1'b0;
            bus.err   <= 1'b0;
            bus.rdata <= '0;
            bus.busy  <= 1'b0;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_asrv32_mem_responder.sv
// tb/tb_asrv32_mem_responder.sv - randomized self-checking bench for asrv32_mem_responder at three wait settings
module tb_asrv32_mem_responder;
  localparam int     MEM_WORDS = 1024;
  localparam longint BASE      = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n  [3];
  logic        req    [3];
  logic        wr_en  [3];
  logic [31:0] addr   [3];
  logic [31:0] wdata  [3];
  logic [3:0]  wstrb  [3];
  logic [31:0] rdata_o[3];
  logic        ack_o  [3];
  logic        err_o  [3];
  logic        busy_o [3];

  int tests = 0;
  int fails = 0;
  int wc [3] = '{1, 0, 3};
  logic [31:0] mdl [3][MEM_WORDS];

  // Instance 0: one wait state, 1: none, 2: three.
  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int unsigned WC = (g == 0) ? 1 : ((g == 1) ? 0 : 3);
    asrv32_mem_responder_if bus ();
    assign bus.req    = req[g];
    assign bus.wr_en  = wr_en[g];
    assign bus.addr   = addr[g];
    assign bus.wdata  = wdata[g];
    assign bus.wstrb  = wstrb[g];
    assign rdata_o[g] = bus.rdata;
    assign ack_o[g]   = bus.ack;
    assign err_o[g]   = bus.err;
    assign busy_o[g]  = bus.busy;
    asrv32_mem_responder #(.MEM_WORDS(MEM_WORDS), .BASE_ADDR(32'h0), .WAIT_CYCLES(WC)) u_dut (
      .i_clk   (clk),
      .i_rst_n (rst_n[g]),
      .bus     (bus)
    );
  end

  always @(negedge clk) begin
    for (int s = 0; s < 3; s++) begin
      if (rst_n[s] === 1'b1 && $isunknown(req[s])) begin
        fails++;
        $display("FAIL req_x: instance %0d req=%b required 0 or 1", s, req[s]);
      end
    end
  end

  function automatic bit exp_err(logic [31:0] a);
    longint la = longint'({32'h0, a});
    return (a[1:0] != 2'b00) || (la < BASE) || (la >= BASE + 4 * MEM_WORDS);
  endfunction

  function automatic int widx(logic [31:0] a);
    return int'((longint'({32'h0, a}) - BASE) / 4);
  endfunction

  task automatic model_write(input int s, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] st);
    if (!exp_err(a)) begin
      for (int k = 0; k < 4; k++) if (st[k]) mdl[s][widx(a)][8*k +: 8] = wd[8*k +: 8];
    end
  endtask

  // Drives one request, holds it until ack, and reports what was seen; clean=0 if busy/idle-zero rules broke.
  task automatic access(input int s, input bit wr, input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] st, output logic [31:0] rd, output logic er,
                        output int lat, output bit clean);
    clean = 1'b1; lat = -1; rd = '0; er = 1'b0;
    @(negedge clk);
    req[s] = 1'b1; wr_en[s] = wr; addr[s] = a; wdata[s] = wd; wstrb[s] = st;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (busy_o[s] !== 1'b1) clean = 1'b0;
      if (ack_o[s] === 1'b1) begin
        rd = rdata_o[s]; er = err_o[s]; lat = k;
        break;
      end
      if (rdata_o[s] !== 32'h0 || err_o[s] !== 1'b0) clean = 1'b0;
    end
    req[s] = 1'b0;
    @(negedge clk);
    if (ack_o[s] !== 1'b0 || busy_o[s] !== 1'b0 || rdata_o[s] !== 32'h0 || err_o[s] !== 1'b0) clean = 1'b0;
  endtask

  task automatic test_reset;
    for (int s = 0; s < 3; s++) begin
      rst_n[s] = 1'b0; req[s] = 1'b0; wr_en[s] = 1'b0;
      addr[s] = '0; wdata[s] = '0; wstrb[s] = '0;
    end
    repeat (3) @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      tests++;
      if ({ack_o[s], err_o[s], busy_o[s], rdata_o[s]} !== 35'h0) begin
        fails++;
        $display("FAIL reset_outputs: inst %0d ack=%b err=%b busy=%b rdata=%h required all 0",
                 s, ack_o[s], err_o[s], busy_o[s], rdata_o[s]);
      end
      rst_n[s] = 1'b1;
    end
    @(negedge clk);
  endtask

  task automatic test_basic;
    logic [31:0] rd; logic er; int lat; bit cl;
    logic [31:0] a_list  [9] = '{32'h10, 32'h10, 32'h10, 32'h10, 32'h10, 32'h10, 32'h12, 32'h0, 32'h1000};
    logic [31:0] d_list  [9] = '{32'hDEADBEEF, 32'h0, 32'h000000AA, 32'h0, 32'h0, 32'h0, 32'h0, 32'h11111111, 32'h99999999};
    logic [3:0]  s_list  [9] = '{4'hF, 4'h0, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 4'hF, 4'hF};
    bit          w_list  [9] = '{1, 0, 1, 0, 1, 0, 0, 1, 1};
    logic [31:0] er_list [9] = '{32'h0, 32'hDEADBEEF, 32'h0, 32'hDEADBEAA, 32'h0, 32'hDEADBEAA, 32'h0, 32'h0, 32'h0};
    bit          ee_list [9] = '{0, 0, 0, 0, 0, 0, 1, 0, 1};
    for (int i = 0; i < 9; i++) begin
      access(0, w_list[i], a_list[i], d_list[i], s_list[i], rd, er, lat, cl);
      if (w_list[i]) model_write(0, a_list[i], d_list[i], s_list[i]);
      tests++;
      if (rd !== er_list[i] || er !== ee_list[i] || lat != 2 || !cl) begin
        fails++;
        $display("FAIL basic_%0d: rdata=%h err=%b lat=%0d clean=%b required rdata=%h err=%b lat=2 clean=1",
                 i, rd, er, lat, cl, er_list[i], ee_list[i]);
      end
    end
    access(0, 0, 32'h0, 32'h0, 4'h0, rd, er, lat, cl);
    tests++;
    if (rd !== 32'h11111111 || er !== 1'b0) begin
      fails++;
      $display("FAIL word0_after_oob_write: rdata=%h err=%b required 11111111 0", rd, er);
    end
    access(0, 0, 32'hFFFF_FFFC, 32'h0, 4'h0, rd, er, lat, cl);
    tests++;
    if (rd !== 32'h0 || er !== 1'b1 || lat != 2) begin
      fails++;
      $display("FAIL read_top_addr: rdata=%h err=%b lat=%0d required 0 1 2", rd, er, lat);
    end
  endtask

  task automatic test_latency;
    logic [31:0] rd; logic er; int lat; bit cl; logic [31:0] d;
    for (int s = 1; s < 3; s++) begin
      d = $urandom;
      access(s, 1, 32'h30, d, 4'hF, rd, er, lat, cl);
      model_write(s, 32'h30, d, 4'hF);
      tests++;
      if (lat != wc[s] + 1 || er !== 1'b0 || !cl) begin
        fails++;
        $display("FAIL latency_write_%0d: lat=%0d err=%b clean=%b required lat=%0d err=0 clean=1", s, lat, er, cl, wc[s] + 1);
      end
      access(s, 0, 32'h30, 32'h0, 4'h0, rd, er, lat, cl);
      tests++;
      if (lat != wc[s] + 1 || rd !== d || !cl) begin
        fails++;
        $display("FAIL latency_read_%0d: lat=%0d rdata=%h clean=%b required lat=%0d rdata=%h clean=1", s, lat, rd, cl, wc[s] + 1, d);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] rd; logic er; int lat; bit cl; int n; bit got;
    logic [31:0] a [3] = '{32'h40, 32'h44, 32'h48};
    logic [31:0] d;
    for (int i = 0; i < 3; i++) begin
      d = $urandom;
      access(1, 1, a[i], d, 4'hF, rd, er, lat, cl);
      model_write(1, a[i], d, 4'hF);
    end
    @(negedge clk);
    req[1] = 1'b1; wr_en[1] = 1'b0; addr[1] = a[0];
    for (int i = 0; i < 3; i++) begin
      got = 1'b0; n = 0;
      for (int k = 1; k <= 10; k++) begin
        @(negedge clk);
        if (ack_o[1] === 1'b1) begin got = 1'b1; n = k; break; end
      end
      tests++;
      if (!got || rdata_o[1] !== mdl[1][widx(a[i])] || n != ((i == 0) ? 1 : 2)) begin
        fails++;
        $display("FAIL b2b_%0d: ack_seen=%b gap=%0d rdata=%h required ack gap=%0d rdata=%h",
                 i, got, n, rdata_o[1], (i == 0) ? 1 : 2, mdl[1][widx(a[i])]);
      end
      if (i < 2) addr[1] = a[i + 1];
      else req[1] = 1'b0;
    end
    @(negedge clk);
    tests++;
    if (ack_o[1] !== 1'b0) begin
      fails++;
      $display("FAIL b2b_tail: ack=%b required 0", ack_o[1]);
    end
  endtask

  task automatic test_random;
    logic [31:0] rd; logic er; int lat; bit cl;
    logic [31:0] a, d, exp_rd; logic [3:0] st; bit wr, ee;
    for (int s = 0; s < 3; s++) begin
      for (int i = 0; i < 8; i++) begin
        d = $urandom;
        access(s, 1, 32'h100 + 4 * i, d, 4'hF, rd, er, lat, cl);
        model_write(s, 32'h100 + 4 * i, d, 4'hF);
      end
      for (int i = 0; i < 25; i++) begin
        case ($urandom_range(0, 9))
          7:       a = 32'h100 + 4 * $urandom_range(0, 7) + $urandom_range(1, 3);
          8:       a = 32'h1000 + 4 * $urandom_range(0, 255);
          9:       a = 32'hFFFF_FFFC;
          default: a = 32'h100 + 4 * $urandom_range(0, 7);
        endcase
        wr = 1'($urandom_range(0, 1));
        d  = $urandom;
        st = 4'($urandom_range(0, 15));
        ee = exp_err(a);
        exp_rd = 32'h0;
        if (!wr && !ee) exp_rd = mdl[s][widx(a)];
        access(s, wr, a, d, st, rd, er, lat, cl);
        if (wr) model_write(s, a, d, st);
        tests++;
        if (rd !== exp_rd || er !== ee || lat != wc[s] + 1 || !cl) begin
          fails++;
          $display("FAIL random_%0d_%0d: addr=%h wr=%b rdata=%h err=%b lat=%0d clean=%b required rdata=%h err=%b lat=%0d clean=1",
                   s, i, a, wr, rd, er, lat, cl, exp_rd, ee, wc[s] + 1);
        end
      end
    end
  endtask

  task automatic test_reset_mid_wait;
    logic [31:0] rd; logic er; int lat; bit cl; bit seen;
    access(2, 1, 32'h20, 32'hCAFEF00D, 4'hF, rd, er, lat, cl);
    model_write(2, 32'h20, 32'hCAFEF00D, 4'hF);
    @(negedge clk);
    req[2] = 1'b1; wr_en[2] = 1'b1; addr[2] = 32'h20; wdata[2] = 32'h12345678; wstrb[2] = 4'hF;
    repeat (2) @(negedge clk);
    rst_n[2] = 1'b0; req[2] = 1'b0;
    #1;
    tests++;
    if ({ack_o[2], err_o[2], busy_o[2], rdata_o[2]} !== 35'h0) begin
      fails++;
      $display("FAIL midwait_reset_outputs: ack=%b err=%b busy=%b rdata=%h required all 0",
               ack_o[2], err_o[2], busy_o[2], rdata_o[2]);
    end
    @(negedge clk);
    rst_n[2] = 1'b1;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (ack_o[2] !== 1'b0 || busy_o[2] !== 1'b0) seen = 1'b1;
    end
    tests++;
    if (seen) begin
      fails++;
      $display("FAIL midwait_no_ack: activity=%b required 0", seen);
    end
    access(2, 0, 32'h20, 32'h0, 4'h0, rd, er, lat, cl);
    tests++;
    if (rd !== mdl[2][widx(32'h20)] || er !== 1'b0) begin
      fails++;
      $display("FAIL midwait_prior_data: rdata=%h err=%b required %h 0", rd, er, mdl[2][widx(32'h20)]);
    end
  endtask

  initial begin
    for (int s = 0; s < 3; s++) begin
      rst_n[s] = 1'b0; req[s] = 1'b0; wr_en[s] = 1'b0;
      addr[s] = '0; wdata[s] = '0; wstrb[s] = '0;
    end
    test_reset();
    test_basic();
    test_latency();
    test_back_to_back();
    test_random();
    test_reset_mid_wait();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/asrv32_mem_responder.md
Name: asrv32_mem_responder

Overview:
Memory-side responder for the ASRV32 core's fetch/load/store request interface. It is the slave end of the handshake the core's stage FSM drives during FETCH and MEMORYACCESS. The block holds a word-addressed internal RAM, accepts one request at a time, and returns read data or a write commit. Every response is a single-cycle ack pulse, after a programmable number of wait states.

Parameters:
MEM_WORDS, 1024, RAM depth in 32-bit words (power of two, >=4)
BASE_ADDR, 32'h0000_0000, byte address of word 0 (MEM_WORDS*4-aligned)
WAIT_CYCLES, 1, extra wait states per access (0..15)

Ports:
i_clk  in  1  clock
i_rst_n  in  1  asynchronous active-low reset
i_req  in  1  request valid; sampled only in IDLE
i_wr_en  in  1  1=write, 0=read; sampled with i_req
i_addr  in  32  byte address
i_wdata  in  32  write data
i_wstrb  in  4  byte enables; bit k writes i_wdata[8k+7:8k]; ignored on reads
o_rdata  out  32  read data; valid only while o_ack=1, else 0
o_ack  out  1  one-cycle response pulse
o_err  out  1  error flag; valid only while o_ack=1, else 0
o_busy  out  1  1 in WAIT or RESP

Behaviour:
- Reset is asynchronous and active-low, on i_rst_n, clocked by i_clk.
  - Reset values: state=IDLE, o_ack=0, o_err=0, o_rdata=0, o_busy=0, wait counter=0, latched request cleared.
  - RAM contents are not reset.
- States are IDLE, WAIT and RESP.
- IDLE:
  - i_req=1 at edge N latches addr, wdata, wstrb and wr_en.
  - If WAIT_CYCLES=0, next state is RESP. Otherwise next state is WAIT with counter=WAIT_CYCLES-1.
- WAIT:
  - Counter decrements each edge.
  - At the edge where counter==0, go to RESP.
  - i_req and all other inputs are ignored.
- RESP:
  - o_ack=1 for exactly this one cycle.
  - Unconditional return to IDLE at the next edge.
  - i_req is not accepted in RESP.
- Latency: ack is high in cycle N+1+WAIT_CYCLES, where cycle N is the cycle in which i_req was sampled.
  - Minimum request-to-request spacing is WAIT_CYCLES+2 cycles.
- The requester holds i_req until it sees o_ack and must deassert it in the ack cycle.
  - If i_req is still 1 in the IDLE cycle after RESP, that is a new request.
- Error condition, evaluated on the latched request:
  - err = (addr[1:0]!=0) OR addr<BASE_ADDR OR addr>=BASE_ADDR+4*MEM_WORDS.
  - Compute the upper bound in 33 bits so there is no wrap.
- Index: word = (addr-BASE_ADDR)>>2, using log2(MEM_WORDS) bits.
- Read:
  - o_rdata is registered and equals RAM[word] as of the edge entering RESP.
  - o_rdata returns to 0 when leaving RESP.
  - On error, o_rdata=0 and o_err=1.
- Write:
  - Commits on the edge entering RESP, byte-masked by wstrb.
  - On error, no RAM change and o_err=1.
  - wstrb=4'b0000 gives o_ack with o_err=0 and no change.
- A read following a write to the same word returns the new data (the write is committed before the next request can be accepted).
- Reset asserted in WAIT aborts the access: no write, no ack.
  - Reset asserted in the RESP cycle: the write has already committed, and the ack drops immediately.
- X on i_req in IDLE is a protocol violation. The bench flags it; RTL behaviour is undefined.

Test Plan:
- WAIT_CYCLES=1: write 0xDEADBEEF, wstrb=4'hF, addr 0x10 at cycle 0. Expect ack+err=0 in cycle 2. Read 0x10 gives o_rdata=0xDEADBEEF in its ack cycle, with o_rdata=0 in all other cycles.
- Byte strobe: after the above, write 0x000000AA with wstrb=4'b0001 to 0x10. Read gives 0xDEADBEAA. Then write wstrb=0. Read is still 0xDEADBEAA.
- Errors:
  - Read addr 0x12 gives ack, err=1, rdata=0.
  - Write addr BASE_ADDR+4*MEM_WORDS (0x1000 at defaults) gives err=1, and word 0 is unchanged.
  - Read 0xFFFF_FFFC gives err=1 with no wrap.
- Latency sweep WAIT_CYCLES in {0,3}: ack arrives exactly 1 and 4 cycles after i_req is sampled. o_busy is high from the cycle after sampling through ack. A held i_req during WAIT is ignored (exactly one ack).
- Back-to-back: i_req held continuously for 3 reads at WAIT_CYCLES=0 gives acks every 2 cycles, each with correct data for the address presented at sampling.
- Reset mid-WAIT (WAIT_CYCLES=3): write 0x12345678 to 0x20, pulse i_rst_n low during WAIT. Expect no ack, outputs 0, and a subsequent read of 0x20 returns the prior contents.
